monochrome_pipe: RTL and testbench
==================================

Name: monochrome_pipe

Overview:
Pipelined, parametrised monochrome/tint video filter. It sits between the video generator and the scan-doubler/encoder output stage. It computes a fixed-point luma from RGB and applies a selectable tint mode. Sync and blank signals are carried through the pipeline so they stay aligned with pixel data. Mode changes take effect on a frame boundary to prevent tearing.

Parameters:
CW, 8, width of each colour channel in and out
KR, 80, red luma coefficient (x/256)
KG, 144, green luma coefficient (x/256)
KB, 32, blue luma coefficient (x/256)
FRAME_SYNC, 1, 1 = mode latched only on vsync rising edge; 0 = mode latched on every ce

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ce  in  1  pixel clock enable; pipeline advances only when ce=1
mode_in  in  3  requested mode: 0 pass, 1 green, 2 amber, 3 white, 4 sepia, 5-7 pass
ri  in  CW  red in
gi  in  CW  green in
bi  in  CW  blue in
hsync_in  in  1  horizontal sync in
vsync_in  in  1  vertical sync in
blank_in  in  1  blanking in
ro  out  CW  red out
go  out  CW  green out
bo  out  CW  blue out
hsync_out  out  1  hsync delayed 3 ce-cycles
vsync_out  out  1  vsync delayed 3 ce-cycles
blank_out  out  1  blank delayed 3 ce-cycles
mode_active  out  3  currently latched mode

Behaviour:
- Reset (sync, clk edge with reset=1) clears all registers: ro/go/bo=0, hsync_out/vsync_out/blank_out=0, mode_active=0, vsync edge detector=0. Reset overrides ce.
- Everything holds its value when ce=0.
- Mode latch. vsync_prev<=vsync_in on each ce.
  - FRAME_SYNC=1: on a ce where vsync_in=1 and vsync_prev=0, mode_active<=mode_in.
  - FRAME_SYNC=0: mode_active<=mode_in on every ce.
  - The pixel accepted on the same ce uses the old mode_active.
- Stage 1 (ce):
  - pr=ri*KR, pg=gi*KG, pb=bi*KB, each CW+8 bits.
  - Raw RGB, mode_active, hsync, vsync and blank are registered alongside.
- Stage 2 (ce):
  - sum=pr+pg+pb, CW+10 bits.
  - gray=sum>>8; if gray>2^CW-1, gray saturates to 2^CW-1.
  - Raw RGB, mode, sync and blank are carried forward.
- Stage 3 (ce), output registers, by the carried mode:
  - 0/5/6/7 pass: ro=r, go=g, bo=b.
  - 1 green: ro=0, go=gray, bo=0.
  - 2 amber: ro=gray, go=gray>>1, bo=0.
  - 3 white: ro=go=bo=gray.
  - 4 sepia: ro=sat(gray+(gray>>2)), go=gray, bo=gray-(gray>>2).
  - If the carried blank=1, ro=go=bo=0 regardless of mode.
- Latency: exactly 3 ce-cycles from input to output for data, sync and blank. There are no bubbles; throughput is 1 pixel per ce.
- The mode travels with each pixel through the pipe. A mode change affects whole pixels only, never a partially processed one.
- Simultaneous events:
  - reset and ce together: reset wins.
  - vsync rising edge with ce=0: ignored until a ce samples it, since the edge detector runs only on ce.
- Reset mid-frame: the pipe is flushed to zeros. Output is blank-equivalent (all zero) for 3 ce after release. mode_active returns to pass.

Test Plan:
- Mode 3 active, input FF/FF/FF, blank=0 -> 3 ce later ro=go=bo=FF. Separately, input FF/00/00 -> 4F/4F/4F; 00/FF/00 -> 8F/8F/8F; 00/00/FF -> 1F/1F/1F.
- Modes 2, 1 and 4 with input FF/FF/FF -> amber FF/7F/00; green 00/FF/00; sepia FF/FF/C0. Input 40/40/40 in sepia -> 50/40/30.
- FRAME_SYNC=1, mode 0 latched, mode_in changed to 3 mid-frame -> outputs stay pass-through and mode_active=0. After the vsync rising edge, mode_active=3 on the next clk. The first gray pixel appears at the output exactly 3 ce after the first pixel accepted with the new mode.
- ce toggled 1,0,0,1,1,1 with a pixel stream and a hsync pulse -> outputs and hsync_out change only on ce cycles. Pixel N appears on the 3rd ce after its capture; hsync_out stays aligned with its pixel.
- Assert reset for 1 clk mid-stream with ce=1 -> next clk all outputs 0 and mode_active=0. The first new input appears after 3 ce.
- blank_in=1 with input FF/FF/FF in mode 0 -> ro/go/bo=0 and blank_out=1, 3 ce later.

Source files
------------

// File: rtl/monochrome_pipe.sv
// monochrome_pipe
//   Three-stage monochrome/tint video filter. It computes a fixed-point luma
//   from RGB and then applies a tint selected by the latched mode. Sync and
//   blank travel with the pixel, so they leave aligned with the data that
//   came in beside them.
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   ce                pixel clock enable; every register holds while ce=0
//   mode_in           requested mode (0 pass, 1 green, 2 amber, 3 white,
//                     4 sepia, 5-7 pass)
//   ri/gi/bi          colour in, CW bits per channel
//   hsync_in/vsync_in/blank_in  timing in
//   ro/go/bo          colour out, 3 ce-cycles after input
//   hsync_out/vsync_out/blank_out  timing out, same 3 ce-cycle delay
//   mode_active       mode currently applied to newly accepted pixels
module monochrome_pipe #(
   parameter int CW         = 8,
   parameter int KR         = 80,
   parameter int KG         = 144,
   parameter int KB         = 32,
   parameter int FRAME_SYNC = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ce,
   input  logic [2:0]    mode_in,
   input  logic [CW-1:0] ri,
   input  logic [CW-1:0] gi,
   input  logic [CW-1:0] bi,
   input  logic          hsync_in,
   input  logic          vsync_in,
   input  logic          blank_in,
   output logic [CW-1:0] ro,
   output logic [CW-1:0] go,
   output logic [CW-1:0] bo,
   output logic          hsync_out,
   output logic          vsync_out,
   output logic          blank_out,
   output logic [2:0]    mode_active
);

   localparam int PW = CW + 8;
   localparam int SW = CW + 10;

   // Per-pixel side data carried unchanged through stages 1 and 2.
   typedef struct packed {
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
      logic [2:0]    mode;
      logic          hs;
      logic          vs;
      logic          bl;
   } side_t;

   side_t         s1, s2;
   logic [PW-1:0] pr, pg, pb;
   logic [CW-1:0] gray;
   logic          vsync_prev;

   logic [SW-1:0] sum, sh;
   logic [CW-1:0] gray_n;
   logic [CW:0]   sep_r;
   logic [CW-1:0] r_n, g_n, b_n;

   // Coefficients sum to 256, but a custom set can exceed it, so the luma is
   // clamped to full scale rather than wrapped.
   always_comb begin
      sum    = SW'(pr) + SW'(pg) + SW'(pb);
      sh     = sum >> 8;
      gray_n = (sh > SW'(2**CW - 1)) ? '1 : sh[CW-1:0];
   end

   always_comb begin
      sep_r = {1'b0, gray} + {3'b000, gray[CW-1:2]};
      r_n   = s2.r;
      g_n   = s2.g;
      b_n   = s2.b;
      unique case (s2.mode)
         3'd1: begin r_n = '0;   g_n = gray;                  b_n = '0;   end
         3'd2: begin r_n = gray; g_n = {1'b0, gray[CW-1:1]};  b_n = '0;   end
         3'd3: begin r_n = gray; g_n = gray;                  b_n = gray; end
         3'd4: begin
            r_n = sep_r[CW] ? '1 : sep_r[CW-1:0];
            g_n = gray;
            b_n = gray - {2'b00, gray[CW-1:2]};
         end
         default: ;
      endcase
      if (s2.bl) begin
         r_n = '0;
         g_n = '0;
         b_n = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1          <= '0;
         s2          <= '0;
         pr          <= '0;
         pg          <= '0;
         pb          <= '0;
         gray        <= '0;
         vsync_prev  <= 1'b0;
         mode_active <= '0;
         ro          <= '0;
         go          <= '0;
         bo          <= '0;
         hsync_out   <= 1'b0;
         vsync_out   <= 1'b0;
         blank_out   <= 1'b0;
      end else if (ce) begin
         // The mode update lands together with stage 1 capturing the old
         // mode_active, so a pixel is never processed under a mixed mode.
         vsync_prev <= vsync_in;
         if (FRAME_SYNC == 0 || (vsync_in && !vsync_prev))
            mode_active <= mode_in;

         pr <= PW'(ri) * PW'(KR);
         pg <= PW'(gi) * PW'(KG);
         pb <= PW'(bi) * PW'(KB);
         s1 <= '{r: ri, g: gi, b: bi, mode: mode_active,
                 hs: hsync_in, vs: vsync_in, bl: blank_in};

         gray <= gray_n;
         s2   <= s1;

         ro        <= r_n;
         go        <= g_n;
         bo        <= b_n;
         hsync_out <= s2.hs;
         vsync_out <= s2.vs;
         blank_out <= s2.bl;
      end
   end

endmodule

// File: tb/tb_monochrome_pipe.sv
// Directed bench for monochrome_pipe: a vector table for the per-mode colour
// maths, and hand-written sequences for frame-synchronous mode latching,
// ce gaps, and reset in the middle of a stream.
module tb_monochrome_pipe;

   logic       clk = 1'b0;
   logic       reset, ce;
   logic [2:0] mode_in;
   logic [7:0] ri, gi, bi;
   logic       hsync_in, vsync_in, blank_in;
   logic [7:0] ro, go, bo;
   logic       hsync_out, vsync_out, blank_out;
   logic [2:0] mode_active;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   monochrome_pipe dut (
      .clk(clk), .reset(reset), .ce(ce), .mode_in(mode_in),
      .ri(ri), .gi(gi), .bi(bi),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
      .ro(ro), .go(go), .bo(bo),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
      .mode_active(mode_active)
   );

   typedef struct {
      logic [2:0] mode;
      logic [7:0] r, g, b;
      logic       bl;
      logic [7:0] er, eg, eb;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are read there too.
   task automatic tick(input logic c);
      ce = c;
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      ri = r; gi = g; bi = b;
   endtask

   task automatic chk_rgb(input string nm, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      chk({nm, ".ro"}, ro, r);
      chk({nm, ".go"}, go, g);
      chk({nm, ".bo"}, bo, b);
   endtask

   // Latch a mode by producing a vsync rising edge.
   task automatic set_mode(input logic [2:0] m);
      mode_in = m; blank_in = 1'b0; hsync_in = 1'b0;
      vsync_in = 1'b0; tick(1);
      vsync_in = 1'b1; tick(1);
      vsync_in = 1'b0; tick(1);
   endtask

   initial begin
      vecs[0] = '{3'd3, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 8'hFF};
      vecs[1] = '{3'd3, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h4F, 8'h4F, 8'h4F};
      vecs[2] = '{3'd3, 8'h00, 8'hFF, 8'h00, 1'b0, 8'h8F, 8'h8F, 8'h8F};
      vecs[3] = '{3'd3, 8'h00, 8'h00, 8'hFF, 1'b0, 8'h1F, 8'h1F, 8'h1F};
      vecs[4] = '{3'd2, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hFF, 8'h7F, 8'h00};
      vecs[5] = '{3'd1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00};
      vecs[6] = '{3'd4, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 8'hC0};
      vecs[7] = '{3'd4, 8'h40, 8'h40, 8'h40, 1'b0, 8'h50, 8'h40, 8'h30};
      vecs[8] = '{3'd0, 8'h12, 8'h34, 8'h56, 1'b0, 8'h12, 8'h34, 8'h56};
      vecs[9] = '{3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'h00, 8'h00};

      reset = 1'b1; ce = 1'b1; mode_in = 3'd5;
      hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
      pix(8'hAA, 8'hBB, 8'hCC);
      tick(1);
      tick(1);
      chk_rgb("reset", 8'h00, 8'h00, 8'h00);
      chk("reset.hsync", hsync_out, 0);
      chk("reset.vsync", vsync_out, 0);
      chk("reset.blank", blank_out, 0);
      chk("reset.mode", mode_active, 0);
      reset = 1'b0;

      // Per-mode colour maths, 3 ce from capture to output.
      foreach (vecs[i]) begin
         set_mode(vecs[i].mode);
         chk($sformatf("vec%0d.mode", i), mode_active, vecs[i].mode);
         pix(vecs[i].r, vecs[i].g, vecs[i].b);
         blank_in = vecs[i].bl;
         tick(1); tick(1); tick(1);
         chk_rgb($sformatf("vec%0d", i), vecs[i].er, vecs[i].eg, vecs[i].eb);
         chk($sformatf("vec%0d.blank", i), blank_out, vecs[i].bl);
         blank_in = 1'b0;
      end

      // Mode request mid-frame is ignored until the vsync rising edge.
      set_mode(3'd0);
      mode_in = 3'd3;
      pix(8'hFF, 8'h00, 8'h00);
      tick(1); tick(1); tick(1);
      chk_rgb("midframe", 8'hFF, 8'h00, 8'h00);
      chk("midframe.mode", mode_active, 0);
      vsync_in = 1'b1; tick(1);          // P0 accepted under the old mode
      chk("vsedge.mode", mode_active, 3);
      vsync_in = 1'b0; tick(1);          // P1 accepted under mode 3
      tick(1);
      chk_rgb("vsedge.p0", 8'hFF, 8'h00, 8'h00);
      chk("vsedge.vsync", vsync_out, 1);
      tick(1);
      chk_rgb("vsedge.p1", 8'h4F, 8'h4F, 8'h4F);
      chk("vsedge.vsync_off", vsync_out, 0);

      // Reset mid-stream with ce=1.
      pix(8'hFF, 8'hFF, 8'hFF);
      tick(1); tick(1); tick(1);
      chk_rgb("prerst", 8'hFF, 8'hFF, 8'hFF);
      reset = 1'b1; tick(1);
      chk_rgb("midrst", 8'h00, 8'h00, 8'h00);
      chk("midrst.mode", mode_active, 0);
      reset = 1'b0;
      pix(8'h12, 8'h34, 8'h56);
      tick(1);
      chk_rgb("postrst1", 8'h00, 8'h00, 8'h00);
      tick(1);
      chk_rgb("postrst2", 8'h00, 8'h00, 8'h00);
      tick(1);
      chk_rgb("postrst3", 8'h12, 8'h34, 8'h56);
      chk("postrst.mode", mode_active, 0);

      // ce gaps: pixels and hsync advance only on ce.
      pix(8'h00, 8'h00, 8'h00); hsync_in = 1'b0;
      tick(1); tick(1); tick(1);
      pix(8'h11, 8'h22, 8'h33); hsync_in = 1'b1;
      tick(1);                                   // capture A
      chk_rgb("ce.t1", 8'h00, 8'h00, 8'h00);
      pix(8'h99, 8'h99, 8'h99);
      tick(0);
      chk_rgb("ce.t2", 8'h00, 8'h00, 8'h00);
      chk("ce.t2.hsync", hsync_out, 0);
      tick(0);
      chk_rgb("ce.t3", 8'h00, 8'h00, 8'h00);
      pix(8'h44, 8'h55, 8'h66); hsync_in = 1'b0;
      tick(1);                                   // capture B
      chk_rgb("ce.t4", 8'h00, 8'h00, 8'h00);
      chk("ce.t4.hsync", hsync_out, 0);
      pix(8'h77, 8'h88, 8'h99);
      tick(1);                                   // A reaches output
      chk_rgb("ce.t5", 8'h11, 8'h22, 8'h33);
      chk("ce.t5.hsync", hsync_out, 1);
      pix(8'h00, 8'h00, 8'h00);
      tick(0);
      chk_rgb("ce.hold", 8'h11, 8'h22, 8'h33);
      chk("ce.hold.hsync", hsync_out, 1);
      tick(1);                                   // B reaches output
      chk_rgb("ce.t6", 8'h44, 8'h55, 8'h66);
      chk("ce.t6.hsync", hsync_out, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
